// File: rtl/brq_ifu_tlul_host.sv
// Instruction-fetch host adapter: core req/gnt/rvalid to TL-UL Get, in-order source tracking.
// Optional macro BRQ_IFU_TLUL_RSP_REG_EN registers the response outputs (1-cycle D-to-rvalid latency).
module brq_ifu_tlul_host #(
  parameter int NUM_OUTSTANDING = 2,
  parameter int SRC_W           = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,

  input  logic             instr_req_i,
  input  logic [31:0]      instr_addr_i,
  output logic             instr_gnt_o,
  output logic             instr_rvalid_o,
  output logic [31:0]      instr_rdata_o,
  output logic             instr_err_o,

  output logic             tl_a_valid_o,
  output logic [2:0]       tl_a_opcode_o,
  output logic [2:0]       tl_a_param_o,
  output logic [1:0]       tl_a_size_o,
  output logic [SRC_W-1:0] tl_a_source_o,
  output logic [31:0]      tl_a_address_o,
  output logic [3:0]       tl_a_mask_o,
  output logic [31:0]      tl_a_data_o,
  input  logic             tl_a_ready_i,

  input  logic             tl_d_valid_i,
  input  logic [2:0]       tl_d_opcode_i,
  input  logic [SRC_W-1:0] tl_d_source_i,
  input  logic [31:0]      tl_d_data_i,
  input  logic             tl_d_error_i,
  output logic             tl_d_ready_o,

  output logic             busy_o,
  output logic             spurious_rsp_o
);

  localparam int               CNT_W    = $clog2(NUM_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_OUTSTANDING);
  localparam logic [SRC_W-1:0] SRC_LAST = SRC_W'(NUM_OUTSTANDING - 1);
  localparam logic [2:0]       OP_GET   = 3'd4;
  localparam logic [2:0]       OP_ACK_D = 3'd1;

  logic [CNT_W-1:0] out_cnt;
  logic [SRC_W-1:0] src_issue_q;
  logic [SRC_W-1:0] src_expect_q;
  logic             full;
  logic             d_hit;
  logic             d_spur;
  logic             rsp_err;
  logic             unused_addr_lsb;

  assign full            = (out_cnt == CNT_MAX);
  assign unused_addr_lsb = ^instr_addr_i[1:0];

  assign tl_a_valid_o   = instr_req_i & ~full;
  assign instr_gnt_o    = tl_a_valid_o & tl_a_ready_i;
  assign tl_a_opcode_o  = OP_GET;
  assign tl_a_param_o   = 3'd0;
  assign tl_a_size_o    = 2'd2;
  assign tl_a_source_o  = src_issue_q;
  assign tl_a_address_o = {instr_addr_i[31:2], 2'b00};
  assign tl_a_mask_o    = 4'hF;
  assign tl_a_data_o    = 32'd0;
  assign tl_d_ready_o   = 1'b1;

  // A beat with nothing outstanding cannot belong to any Get we issued, so it is dropped.
  assign d_hit          = tl_d_valid_i & (out_cnt != '0) & ~rst_i;
  assign d_spur         = tl_d_valid_i & (out_cnt == '0) & ~rst_i;
  assign spurious_rsp_o = d_spur;
  assign rsp_err        = tl_d_error_i | (tl_d_opcode_i != OP_ACK_D) |
                          (tl_d_source_i != src_expect_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_cnt      <= '0;
      src_issue_q  <= '0;
      src_expect_q <= '0;
    end else begin
      case ({instr_gnt_o, d_hit})
        2'b10:   out_cnt <= out_cnt + CNT_W'(1);
        2'b01:   out_cnt <= out_cnt - CNT_W'(1);
        default: out_cnt <= out_cnt;
      endcase
      if (instr_gnt_o) begin
        src_issue_q <= (src_issue_q == SRC_LAST) ? '0 : src_issue_q + SRC_W'(1);
      end
      if (d_hit) begin
        src_expect_q <= (src_expect_q == SRC_LAST) ? '0 : src_expect_q + SRC_W'(1);
      end
    end
  end

`ifdef BRQ_IFU_TLUL_RSP_REG_EN
  logic        rsp_vld_q;
  logic [31:0] rsp_data_q;
  logic        rsp_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= 32'd0;
      rsp_err_q  <= 1'b0;
    end else begin
      rsp_vld_q <= d_hit;
      rsp_err_q <= d_hit & rsp_err;
      if (d_hit) begin
        rsp_data_q <= tl_d_data_i;
      end
    end
  end

  assign instr_rvalid_o = rsp_vld_q;
  assign instr_rdata_o  = rsp_data_q;
  assign instr_err_o    = rsp_err_q;
  assign busy_o         = (out_cnt != '0) | rsp_vld_q;
`else
  assign instr_rvalid_o = d_hit;
  assign instr_rdata_o  = d_hit ? tl_d_data_i : 32'd0;
  assign instr_err_o    = d_hit & rsp_err;
  assign busy_o         = (out_cnt != '0);
`endif

endmodule

// File: tb/tb_brq_ifu_tlul_host.sv
// Directed bench for brq_ifu_tlul_host; response latency expectations follow BRQ_IFU_TLUL_RSP_REG_EN.
module tb_brq_ifu_tlul_host;

`ifdef BRQ_IFU_TLUL_RSP_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;
  logic        tl_a_valid_o;
  logic [2:0]  tl_a_opcode_o;
  logic [2:0]  tl_a_param_o;
  logic [1:0]  tl_a_size_o;
  logic [0:0]  tl_a_source_o;
  logic [31:0] tl_a_address_o;
  logic [3:0]  tl_a_mask_o;
  logic [31:0] tl_a_data_o;
  logic        tl_a_ready_i;
  logic        tl_d_valid_i;
  logic [2:0]  tl_d_opcode_i;
  logic [0:0]  tl_d_source_i;
  logic [31:0] tl_d_data_i;
  logic        tl_d_error_i;
  logic        tl_d_ready_o;
  logic        busy_o;
  logic        spurious_rsp_o;

  int n_run  = 0;
  int n_fail = 0;

  logic        rv1, er1, sp1, rv2, er2, sp2;
  logic [31:0] rd1, rd2;

  always #5 clk_i = ~clk_i;

  brq_ifu_tlul_host #(.NUM_OUTSTANDING(2), .SRC_W(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .tl_a_valid_o(tl_a_valid_o), .tl_a_opcode_o(tl_a_opcode_o), .tl_a_param_o(tl_a_param_o),
    .tl_a_size_o(tl_a_size_o), .tl_a_source_o(tl_a_source_o), .tl_a_address_o(tl_a_address_o),
    .tl_a_mask_o(tl_a_mask_o), .tl_a_data_o(tl_a_data_o), .tl_a_ready_i(tl_a_ready_i),
    .tl_d_valid_i(tl_d_valid_i), .tl_d_opcode_i(tl_d_opcode_i), .tl_d_source_i(tl_d_source_i),
    .tl_d_data_i(tl_d_data_i), .tl_d_error_i(tl_d_error_i), .tl_d_ready_o(tl_d_ready_o),
    .busy_o(busy_o), .spurious_rsp_o(spurious_rsp_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  task automatic grant(input logic [31:0] addr, input logic [31:0] exp_src, input string tag);
    instr_req_i  = 1'b1;
    instr_addr_i = addr;
    #1;
    chk({tag, "_gnt"}, {31'd0, instr_gnt_o}, 32'd1);
    chk({tag, "_src"}, {31'd0, tl_a_source_o}, exp_src);
    cyc();
    instr_req_i = 1'b0;
  endtask

  task automatic d_drive(input logic [2:0] op, input logic src, input logic [31:0] data,
                         input logic err);
    tl_d_valid_i  = 1'b1;
    tl_d_opcode_i = op;
    tl_d_source_i = src;
    tl_d_data_i   = data;
    tl_d_error_i  = err;
    #1;
    rv1 = instr_rvalid_o; rd1 = instr_rdata_o; er1 = instr_err_o; sp1 = spurious_rsp_o;
  endtask

  task automatic d_finish(input string tag, input logic exp_rv, input logic [31:0] exp_d,
                          input logic exp_e);
    cyc();
    tl_d_valid_i = 1'b0;
    #1;
    rv2 = instr_rvalid_o; rd2 = instr_rdata_o; er2 = instr_err_o; sp2 = spurious_rsp_o;
    chk({tag, "_rv_beat"}, {31'd0, rv1}, {31'd0, exp_rv & (LAT == 0)});
    chk({tag, "_rv_next"}, {31'd0, rv2}, {31'd0, exp_rv & (LAT == 1)});
    chk({tag, "_spur_beat"}, {31'd0, sp1}, {31'd0, ~exp_rv});
    chk({tag, "_spur_next"}, {31'd0, sp2}, 32'd0);
    if (exp_rv) begin
      chk({tag, "_rdata"}, (LAT == 1) ? rd2 : rd1, exp_d);
      chk({tag, "_err"}, {31'd0, (LAT == 1) ? er2 : er1}, {31'd0, exp_e});
    end
  endtask

  initial begin
    rst_i = 1'b1; instr_req_i = 1'b1; instr_addr_i = 32'h100; tl_a_ready_i = 1'b1;
    tl_d_valid_i = 1'b0; tl_d_opcode_i = 3'd1; tl_d_source_i = 1'b0;
    tl_d_data_i = 32'd0; tl_d_error_i = 1'b0;
    cyc();
    cyc();
    #1;
    chk("rst_rvalid", {31'd0, instr_rvalid_o}, 32'd0);
    chk("rst_err", {31'd0, instr_err_o}, 32'd0);
    chk("rst_rdata", instr_rdata_o, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_spur", {31'd0, spurious_rsp_o}, 32'd0);
    chk("rst_avalid", {31'd0, tl_a_valid_o}, 32'd1);
    chk("rst_src", {31'd0, tl_a_source_o}, 32'd0);

    rst_i = 1'b0;
    #1;
    chk("c0_gnt", {31'd0, instr_gnt_o}, 32'd1);
    chk("c0_src", {31'd0, tl_a_source_o}, 32'd0);
    chk("c0_addr", tl_a_address_o, 32'h100);
    chk("a_opcode", {29'd0, tl_a_opcode_o}, 32'd4);
    chk("a_param", {29'd0, tl_a_param_o}, 32'd0);
    chk("a_size", {30'd0, tl_a_size_o}, 32'd2);
    chk("a_mask", {28'd0, tl_a_mask_o}, 32'hF);
    chk("a_data", tl_a_data_o, 32'd0);
    chk("d_ready", {31'd0, tl_d_ready_o}, 32'd1);
    cyc();
    instr_addr_i = 32'h106;
    #1;
    chk("c1_gnt", {31'd0, instr_gnt_o}, 32'd1);
    chk("c1_src", {31'd0, tl_a_source_o}, 32'd1);
    chk("c1_addr_align", tl_a_address_o, 32'h104);
    cyc();
    instr_addr_i = 32'h108;
    #1;
    chk("full_avalid", {31'd0, tl_a_valid_o}, 32'd0);
    chk("full_gnt", {31'd0, instr_gnt_o}, 32'd0);
    chk("full_busy", {31'd0, busy_o}, 32'd1);

    d_drive(3'd1, 1'b0, 32'hDEAD_0001, 1'b0);
    chk("full_beat_avalid", {31'd0, tl_a_valid_o}, 32'd0);
    chk("full_beat_gnt", {31'd0, instr_gnt_o}, 32'd0);
    d_finish("b2b0", 1'b1, 32'hDEAD_0001, 1'b0);
    chk("reopen_gnt", {31'd0, instr_gnt_o}, 32'd1);
    chk("reopen_src", {31'd0, tl_a_source_o}, 32'd0);

    d_drive(3'd1, 1'b1, 32'hDEAD_0002, 1'b0);
    chk("sim_gnt", {31'd0, instr_gnt_o}, 32'd1);
    d_finish("b2b1", 1'b1, 32'hDEAD_0002, 1'b0);
    instr_req_i = 1'b0;
    #1;
    chk("sim_busy", {31'd0, busy_o}, 32'd1);
    chk("sim_src_adv", {31'd0, tl_a_source_o}, 32'd1);

    d_drive(3'd1, 1'b0, 32'hDEAD_0003, 1'b0);
    d_finish("sim_rsp", 1'b1, 32'hDEAD_0003, 1'b0);
    chk("drain_busy", {31'd0, busy_o}, LAT);
    cyc();
    #1;
    chk("idle_busy", {31'd0, busy_o}, 32'd0);

    grant(32'h200, 32'd1, "e1");
    d_drive(3'd1, 1'b1, 32'hCAFE_0001, 1'b1);
    d_finish("err_bit", 1'b1, 32'hCAFE_0001, 1'b1);
    grant(32'h204, 32'd0, "e2");
    d_drive(3'd0, 1'b0, 32'hCAFE_0002, 1'b0);
    d_finish("err_opcode", 1'b1, 32'hCAFE_0002, 1'b1);
    grant(32'h208, 32'd1, "e3");
    d_drive(3'd1, 1'b0, 32'hCAFE_0003, 1'b0);
    d_finish("err_source", 1'b1, 32'hCAFE_0003, 1'b1);

    d_drive(3'd1, 1'b0, 32'hBAD0_0000, 1'b0);
    d_finish("spur", 1'b0, 32'd0, 1'b0);
    chk("spur_busy", {31'd0, busy_o}, 32'd0);
    grant(32'h300, 32'd0, "ps");
    d_drive(3'd1, 1'b0, 32'h1234_5678, 1'b0);
    d_finish("post_spur", 1'b1, 32'h1234_5678, 1'b0);

    grant(32'h400, 32'd1, "mr");
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    chk("midrst_rvalid", {31'd0, instr_rvalid_o}, 32'd0);
    d_drive(3'd1, 1'b1, 32'h5555_AAAA, 1'b0);
    d_finish("post_rst", 1'b0, 32'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
